// File: rtl/fractal_sync_pkg.sv
// Shared types and helpers for the fractal synchronisation arbiter:
// selector-width function and the grant-pass enumeration used for debug visibility.
package fractal_sync_pkg;

  typedef enum logic [1:0] {
    URGENT,
    MASKED,
    UNMASKED
  } pass_e;

  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fractal_sync_arb_out_slot.sv
// One valid/ready output register stage of the round-robin arbiter.
// The slot is free when empty or being drained; a free slot reloads or clears.
module fractal_sync_arb_out_slot #(
  parameter type elem_t = logic
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  load,
  input  elem_t load_data,
  input  logic  ready,
  output logic  free,
  output logic  valid,
  output elem_t data
);

  assign free = ~valid | ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (free) begin
      valid <= load;
      if (load) data <= load_data;
    end
  end

endmodule

// File: rtl/fractal_sync_rr_arbiter.sv
// Multi-output fair round-robin arbiter with registered, backpressured output slots.
// Define FRACTAL_SYNC_ARB_AGING_EN to add per-input wait counters and an urgent pass.
module fractal_sync_rr_arbiter
  import fractal_sync_pkg::*;
#(
  parameter int  IN_PORTS  = 1,
  parameter int  OUT_PORTS = 1,
  parameter type arbiter_t = logic,
  parameter int  MAX_WAIT  = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  output logic [IN_PORTS-1:0]  pop_o,
  input  logic [IN_PORTS-1:0]  empty_i,
  input  arbiter_t             element_i [IN_PORTS],
  output logic [OUT_PORTS-1:0] valid_o,
  input  logic [OUT_PORTS-1:0] ready_i,
  output arbiter_t             element_o [OUT_PORTS]
);

  localparam int SEL_W = sel_width(IN_PORTS);

  if (IN_PORTS < 1) begin : g_bad_in_ports
    $error("fractal_sync_rr_arbiter: IN_PORTS must be > 0");
  end
  if (OUT_PORTS < 1) begin : g_bad_out_ports
    $error("fractal_sync_rr_arbiter: OUT_PORTS must be > 0");
  end
  if (MAX_WAIT < 1) begin : g_bad_max_wait
    $error("fractal_sync_rr_arbiter: MAX_WAIT must be >= 1");
  end

  logic [IN_PORTS-1:0]  mask;
  logic [IN_PORTS-1:0]  n_mask;
  logic [IN_PORTS-1:0]  gnt;
  logic [IN_PORTS-1:0]  pending;
  logic                 clear_mask;
  logic                 found;
  logic [OUT_PORTS-1:0] slot_free;
  logic [OUT_PORTS-1:0] slot_load;
  logic [SEL_W-1:0]     sel       [OUT_PORTS];
  pass_e                slot_pass [OUT_PORTS];
  arbiter_t             slot_data [OUT_PORTS];

`ifdef FRACTAL_SYNC_ARB_AGING_EN
  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0] wait_cnt [IN_PORTS];
`endif

  // Grant stage: free slots in ascending order each claim one pending input.
  always_comb begin
    pending    = ~empty_i;
    gnt        = '0;
    clear_mask = 1'b0;
    found      = 1'b0;
    for (int k = 0; k < OUT_PORTS; k++) begin
      slot_load[k] = 1'b0;
      sel[k]       = '0;
      slot_pass[k] = MASKED;
    end
    for (int k = 0; k < OUT_PORTS; k++) begin
      found = 1'b0;
      if (slot_free[k]) begin
`ifdef FRACTAL_SYNC_ARB_AGING_EN
        for (int i = 0; i < IN_PORTS; i++) begin
          if (!found && pending[i] && (wait_cnt[i] == WAIT_MAX)) begin
            found        = 1'b1;
            sel[k]       = SEL_W'(i);
            slot_pass[k] = URGENT;
            gnt[i]       = 1'b1;
            pending[i]   = 1'b0;
          end
        end
`endif
        for (int i = 0; i < IN_PORTS; i++) begin
          if (!found && pending[i] && mask[i]) begin
            found        = 1'b1;
            sel[k]       = SEL_W'(i);
            slot_pass[k] = MASKED;
            gnt[i]       = 1'b1;
            pending[i]   = 1'b0;
          end
        end
        for (int i = 0; i < IN_PORTS; i++) begin
          if (!found && pending[i]) begin
            found        = 1'b1;
            sel[k]       = SEL_W'(i);
            slot_pass[k] = UNMASKED;
            gnt[i]       = 1'b1;
            pending[i]   = 1'b0;
          end
        end
      end
      slot_load[k] = found;
    end
    // Any slot that fell through to the unmasked pass starts a new round.
    for (int k = 0; k < OUT_PORTS; k++) begin
      if (slot_load[k] && (slot_pass[k] == UNMASKED)) clear_mask = 1'b1;
    end
  end

  assign pop_o  = gnt;
  assign n_mask = (gnt & mask & {IN_PORTS{clear_mask}})
                | (~gnt & (mask | {IN_PORTS{clear_mask}}));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) mask <= '1;
    else       mask <= n_mask;
  end

`ifdef FRACTAL_SYNC_ARB_AGING_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < IN_PORTS; i++) wait_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < IN_PORTS; i++) begin
        if (empty_i[i] || gnt[i])        wait_cnt[i] <= '0;
        else if (wait_cnt[i] != WAIT_MAX) wait_cnt[i] <= wait_cnt[i] + 1'b1;
      end
    end
  end
`endif

  // Output stage: one registered valid/ready slot per output port.
  for (genvar k = 0; k < OUT_PORTS; k++) begin : g_slot
    assign slot_data[k] = element_i[sel[k]];

    fractal_sync_arb_out_slot #(
      .elem_t(arbiter_t)
    ) u_slot (
      .clk       (clk_i),
      .rst       (rst_i),
      .load      (slot_load[k]),
      .load_data (slot_data[k]),
      .ready     (ready_i[k]),
      .free      (slot_free[k]),
      .valid     (valid_o[k]),
      .data      (element_o[k])
    );
  end

endmodule

// File: tb/tb_fractal_sync_rr_arbiter.sv
// Directed bench for fractal_sync_rr_arbiter: three instances (4x2, 4x1, 3x1 with MAX_WAIT=2)
// share one clock and reset; the 3x1 sequence depends on FRACTAL_SYNC_ARB_AGING_EN.
module tb_fractal_sync_rr_arbiter;

  typedef logic [7:0] elem_t;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  logic [3:0] a_empty, a_pop;
  elem_t      a_in  [4];
  logic [1:0] a_valid, a_ready;
  elem_t      a_out [2];

  logic [3:0] b_empty, b_pop;
  elem_t      b_in  [4];
  logic       b_valid, b_ready;
  elem_t      b_out [1];

  logic [2:0] c_empty, c_pop;
  elem_t      c_in  [3];
  logic       c_valid, c_ready;
  elem_t      c_out [1];

  fractal_sync_rr_arbiter #(.IN_PORTS(4), .OUT_PORTS(2), .arbiter_t(elem_t), .MAX_WAIT(8)) dut_a (
    .clk_i(clk), .rst_i(rst), .pop_o(a_pop), .empty_i(a_empty), .element_i(a_in),
    .valid_o(a_valid), .ready_i(a_ready), .element_o(a_out));

  fractal_sync_rr_arbiter #(.IN_PORTS(4), .OUT_PORTS(1), .arbiter_t(elem_t), .MAX_WAIT(8)) dut_b (
    .clk_i(clk), .rst_i(rst), .pop_o(b_pop), .empty_i(b_empty), .element_i(b_in),
    .valid_o(b_valid), .ready_i(b_ready), .element_o(b_out));

  fractal_sync_rr_arbiter #(.IN_PORTS(3), .OUT_PORTS(1), .arbiter_t(elem_t), .MAX_WAIT(2)) dut_c (
    .clk_i(clk), .rst_i(rst), .pop_o(c_pop), .empty_i(c_empty), .element_i(c_in),
    .valid_o(c_valid), .ready_i(c_ready), .element_o(c_out));

  task automatic test_reset();
    rst = 1'b1;
    a_empty = '1; b_empty = '1; c_empty = '1;
    a_ready = 2'b11; b_ready = 1'b1; c_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a_in[i] = elem_t'(8'h10 + i);
      b_in[i] = elem_t'(8'hA0 + i);
    end
    for (int i = 0; i < 3; i++) c_in[i] = elem_t'(8'h20 + i);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (a_valid !== 2'b00) begin failures++; $display("FAIL reset_a_valid got=%b exp=00", a_valid); end
    checks++; if (a_out[0] !== 8'h00) begin failures++; $display("FAIL reset_a_out0 got=%h exp=00", a_out[0]); end
    checks++; if (a_out[1] !== 8'h00) begin failures++; $display("FAIL reset_a_out1 got=%h exp=00", a_out[1]); end
    checks++; if (b_valid !== 1'b0) begin failures++; $display("FAIL reset_b_valid got=%b exp=0", b_valid); end
    checks++; if (c_valid !== 1'b0) begin failures++; $display("FAIL reset_c_valid got=%b exp=0", c_valid); end
    checks++; if (a_pop !== 4'b0000) begin failures++; $display("FAIL reset_a_pop got=%b exp=0000", a_pop); end
    checks++; if (b_pop !== 4'b0000) begin failures++; $display("FAIL reset_b_pop got=%b exp=0000", b_pop); end
    checks++; if (c_pop !== 3'b000) begin failures++; $display("FAIL reset_c_pop got=%b exp=000", c_pop); end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_pop;
    elem_t      exp_el;
    @(negedge clk);
    b_empty = 4'b0000;
    for (int k = 0; k < 6; k++) begin
      exp_pop = 4'b0001 << (k % 4);
      exp_el  = elem_t'(8'hA0 + (k % 4));
      #1;
      checks++; if (b_pop !== exp_pop) begin failures++; $display("FAIL rr_pop[%0d] got=%b exp=%b", k, b_pop, exp_pop); end
      @(posedge clk); #1;
      checks++; if (b_valid !== 1'b1) begin failures++; $display("FAIL rr_valid[%0d] got=%b exp=1", k, b_valid); end
      checks++; if (b_out[0] !== exp_el) begin failures++; $display("FAIL rr_data[%0d] got=%h exp=%h", k, b_out[0], exp_el); end
      @(negedge clk);
    end
    b_empty = 4'b1111;
  endtask

  task automatic test_parallel_drain();
    @(negedge clk);
    a_empty = 4'b0000; a_ready = 2'b11;
    #1;
    checks++; if (a_pop !== 4'b0011) begin failures++; $display("FAIL drain_pop0 got=%b exp=0011", a_pop); end
    @(posedge clk); #1;
    checks++; if (a_valid !== 2'b11) begin failures++; $display("FAIL drain_valid0 got=%b exp=11", a_valid); end
    checks++; if (a_out[0] !== 8'h10) begin failures++; $display("FAIL drain_slot0_c0 got=%h exp=10", a_out[0]); end
    checks++; if (a_out[1] !== 8'h11) begin failures++; $display("FAIL drain_slot1_c0 got=%h exp=11", a_out[1]); end
    @(negedge clk); #1;
    checks++; if (a_pop !== 4'b1100) begin failures++; $display("FAIL drain_pop1 got=%b exp=1100", a_pop); end
    @(posedge clk); #1;
    checks++; if (a_out[0] !== 8'h12) begin failures++; $display("FAIL drain_slot0_c1 got=%h exp=12", a_out[0]); end
    checks++; if (a_out[1] !== 8'h13) begin failures++; $display("FAIL drain_slot1_c1 got=%h exp=13", a_out[1]); end
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    a_ready = 2'b01;
    #1;
    checks++; if (a_pop !== 4'b0001) begin failures++; $display("FAIL bp_pop0 got=%b exp=0001", a_pop); end
    @(posedge clk); #1;
    checks++; if (a_valid !== 2'b11) begin failures++; $display("FAIL bp_valid0 got=%b exp=11", a_valid); end
    checks++; if (a_out[0] !== 8'h10) begin failures++; $display("FAIL bp_slot0_c0 got=%h exp=10", a_out[0]); end
    checks++; if (a_out[1] !== 8'h13) begin failures++; $display("FAIL bp_slot1_hold0 got=%h exp=13", a_out[1]); end
    @(negedge clk); #1;
    checks++; if (a_pop !== 4'b0010) begin failures++; $display("FAIL bp_pop1 got=%b exp=0010", a_pop); end
    @(posedge clk); #1;
    checks++; if (a_out[0] !== 8'h11) begin failures++; $display("FAIL bp_slot0_c1 got=%h exp=11", a_out[0]); end
    checks++; if (a_out[1] !== 8'h13) begin failures++; $display("FAIL bp_slot1_hold1 got=%h exp=13", a_out[1]); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++; if (a_valid !== 2'b00) begin failures++; $display("FAIL midrst_valid got=%b exp=00", a_valid); end
    checks++; if (a_out[0] !== 8'h00) begin failures++; $display("FAIL midrst_out0 got=%h exp=00", a_out[0]); end
    checks++; if (a_out[1] !== 8'h00) begin failures++; $display("FAIL midrst_out1 got=%h exp=00", a_out[1]); end
    @(negedge clk);
    rst = 1'b0; a_ready = 2'b11; a_empty = 4'b0000;
    #1;
    checks++; if (a_pop !== 4'b0011) begin failures++; $display("FAIL midrst_mask_pop got=%b exp=0011", a_pop); end
    @(posedge clk); #1;
    checks++; if (a_valid !== 2'b11) begin failures++; $display("FAIL midrst_reload_valid got=%b exp=11", a_valid); end
  endtask

  task automatic test_idle_excess();
    @(negedge clk);
    a_empty = 4'b1011;
    #1;
    checks++; if (a_pop !== 4'b0100) begin failures++; $display("FAIL excess_pop got=%b exp=0100", a_pop); end
    @(posedge clk); #1;
    checks++; if (a_valid !== 2'b01) begin failures++; $display("FAIL excess_valid got=%b exp=01", a_valid); end
    checks++; if (a_out[0] !== 8'h12) begin failures++; $display("FAIL excess_slot0 got=%h exp=12", a_out[0]); end
    checks++; if (a_out[1] !== 8'h11) begin failures++; $display("FAIL excess_slot1_hold got=%h exp=11", a_out[1]); end
    @(negedge clk);
    a_empty = 4'b1111;
    #1;
    checks++; if (a_pop !== 4'b0000) begin failures++; $display("FAIL idle_pop got=%b exp=0000", a_pop); end
    @(posedge clk); #1;
    checks++; if (a_valid !== 2'b00) begin failures++; $display("FAIL idle_valid got=%b exp=00", a_valid); end
    checks++; if (a_out[0] !== 8'h12) begin failures++; $display("FAIL idle_slot0_hold got=%h exp=12", a_out[0]); end
  endtask

  task automatic test_aging();
    logic [2:0] exp_pop [5];
    elem_t      exp_el  [5];
`ifdef FRACTAL_SYNC_ARB_AGING_EN
    exp_pop = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010};
    exp_el  = '{8'h20, 8'h21, 8'h22, 8'h20, 8'h21};
`else
    exp_pop = '{3'b001, 3'b010, 3'b001, 3'b010, 3'b100};
    exp_el  = '{8'h20, 8'h21, 8'h20, 8'h21, 8'h22};
`endif
    @(negedge clk);
    c_empty = 3'b011;
    #1;
    checks++; if (c_pop !== 3'b100) begin failures++; $display("FAIL age_setup_pop got=%b exp=100", c_pop); end
    @(posedge clk); #1;
    checks++; if (c_out[0] !== 8'h22) begin failures++; $display("FAIL age_setup_data got=%h exp=22", c_out[0]); end
    @(negedge clk);
    c_empty = 3'b000;
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++; if (c_pop !== exp_pop[k]) begin failures++; $display("FAIL age_pop[%0d] got=%b exp=%b", k, c_pop, exp_pop[k]); end
      @(posedge clk); #1;
      checks++; if (c_out[0] !== exp_el[k]) begin failures++; $display("FAIL age_data[%0d] got=%h exp=%h", k, c_out[0], exp_el[k]); end
      @(negedge clk);
    end
    c_empty = 3'b111;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_parallel_drain();
    test_backpressure();
    test_reset_mid();
    test_idle_excess();
    test_aging();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
